fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 Parameter XLEN, default 32, meaning address and instruction width.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 imem_req  out  1  instruction memory read request.
REQ-006 imem_addr  out  32  byte address of the requested instruction; equals the PC.
REQ-007 imem_ready  in  1  imem_rdata is valid this cycle for the current request.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 stall  in  1  hazard hold; the IF/ID register and the PC must not advance.
REQ-010 flush  in  1  invalidate the IF/ID register.
REQ-011 branch_taken  in  1  branch redirect from EX.
REQ-012 branch_target  in  32  branch destination.
REQ-013 jump  in  1  jump redirect from ID (j/jal).
REQ-014 if_id_valid  out  1  the IF/ID register holds a live instruction.
REQ-015 if_id_instr  out  32  the instruction held in IF/ID.
REQ-016 if_id_pc4  out  32  PC+4 of the held instruction.
REQ-017 opcode  out  6  if_id_instr[31:26]; drives the control decoder's Opcode input.

Function
REQ-018 The FSM SHALL have states FETCH and HELD.
REQ-019 In FETCH: imem_req=1, imem_addr=pc.
REQ-020 FETCH, imem_ready=1, stall=0, no redirect: IF/ID <= {valid=1, rdata, pc+4}; pc <= pc+4; stay in FETCH.
REQ-021 FETCH, imem_ready=1, stall=1: rdata SHALL be captured into a holding buffer; go to HELD; pc unchanged.
REQ-022 In HELD: imem_req=0. When stall=0, IF/ID SHALL load the buffered word; pc <= pc+4; go to FETCH.
REQ-023 FETCH, imem_ready=0: no state change. IF/ID SHALL be unchanged unless flush or a redirect applies.
REQ-024 Redirect priority SHALL be branch_taken > jump. The redirect SHALL apply in any state, even with stall=1.
REQ-025 On branch_taken: pc <= branch_target.
REQ-026 On jump: pc <= {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
REQ-027 On any redirect: if_id_valid <= 0; the holding buffer and any same-cycle imem response SHALL be discarded; state <= FETCH.
REQ-028 flush=1 without a redirect SHALL clear if_id_valid. The PC and FSM SHALL proceed per REQ-020..023, except that a word accepted in the same cycle is dropped.
REQ-029 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 Fetch latency: an instruction accepted in cycle N SHALL be visible on if_id_* in cycle N+1.

Reset
REQ-031 On rst_n=0 at a clock edge: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc4=0, buffer cleared.
REQ-032 Outputs during reset: imem_req=1 and imem_addr=RESET_PC from the first cycle after reset.
REQ-033 Reset SHALL override stall, flush, redirects and any in-flight response; a response arriving during reset is discarded.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN, when defined, SHALL add output ports perf_fetched (32) and perf_bubbles (32).
REQ-035 perf_fetched SHALL count instructions loaded into IF/ID; perf_bubbles SHALL count cycles with if_id_valid=0.
REQ-036 Both counters SHALL reset to 0 and wrap modulo 2^32.
REQ-037 Without FETCH_PERF_CNT_EN, the counter ports and their logic SHALL be absent.

Structure
REQ-038 Shared package mips_pkg SHALL hold: XLEN, OPCODE_W=6, the opcode constants (R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010, jal=000011), and typedef fetch_state_t {FETCH, HELD}.
REQ-039 A single sub-module if_id_reg SHALL implement the IF/ID pipeline register, with load, hold and clear controls.

Verification
REQ-040 Reset with RESET_PC=32'h100 and imem_ready=1 every cycle -> imem_addr sequence 100, 104, 108; if_id_pc4 = 104 one cycle after the first accept.
REQ-041 stall=1 for 3 cycles when the word at 0x108 arrives -> one imem_req then imem_req=0; IF/ID holds its prior value; the 0x108 word enters IF/ID on the cycle after stall drops; no duplicate fetch occurs.
REQ-042 if_id_instr=32'h0800_0040 (j) with if_id_pc4=32'h1000_0010 and jump=1 -> next imem_addr=32'h1000_0100; if_id_valid=0.
REQ-043 branch_taken=1 (target 32'h200) and jump=1 in the same cycle -> next pc=32'h200.
REQ-044 rst_n=0 while in HELD with a response arriving -> state=FETCH, pc=RESET_PC, if_id_valid=0.
REQ-045 PC=32'hFFFF_FFFC accepted -> next imem_addr=32'h0; with FETCH_PERF_CNT_EN, perf_fetched increments by 1.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared constants, opcodes and fetch FSM state type for the MIPS core.
// Rev    : 1.0
// ============================================================================
package mips_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_t;

    // Pseudo-direct jump target: upper nibble of PC+4, 26-bit index, word aligned.
    function automatic logic [31:0] jump_addr(input logic [31:0] pc4, input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage_if
// Brief  : Instruction-memory, hazard/redirect and IF/ID signals of the fetch stage.
// Rev    : 1.0
// ============================================================================
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic                          imem_req;
    logic [XLEN-1:0]               imem_addr;
    logic                          imem_ready;
    logic [XLEN-1:0]               imem_rdata;
    logic                          stall;
    logic                          flush;
    logic                          branch_taken;
    logic [XLEN-1:0]               branch_target;
    logic                          jump;
    logic                          if_id_valid;
    logic [XLEN-1:0]               if_id_instr;
    logic [XLEN-1:0]               if_id_pc4;
    logic [mips_pkg::OPCODE_W-1:0] opcode;

    modport master (
        output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, opcode,
        input  imem_ready, imem_rdata, stall, flush, branch_taken, branch_target, jump
    );

    modport slave (
        input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, opcode,
        output imem_ready, imem_rdata, stall, flush, branch_taken, branch_target, jump
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module : if_id_reg
// Brief  : IF/ID pipeline register; clear beats load, hold suppresses load.
// Rev    : 1.0
// ============================================================================
module if_id_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            hold_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc4_o
);
    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc4_q;

    // Clear only kills the valid bit; the stale word stays readable for jump decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i && !hold_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Brief  : PC/fetch FSM with stall buffer and redirects; FETCH_PERF_CNT_EN adds counters.
// Rev    : 1.0
// ============================================================================
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_bubbles
`endif
);
    import mips_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jump_target;
    logic            redirect;
    logic            ifid_load;
    logic            ifid_clear;
    logic [XLEN-1:0] ifid_instr_d;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc4;

    assign pc_plus4    = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    assign jump_target = jump_addr(if_id_pc4, if_id_instr);
    assign redirect    = bus.branch_taken | bus.jump;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        ifid_load    = 1'b0;
        ifid_clear   = bus.flush;
        ifid_instr_d = bus.imem_rdata;
        // Redirects win over stall; any word in flight or buffered is dropped.
        if (redirect) begin
            ifid_clear = 1'b1;
            buf_d      = '0;
            state_d    = FETCH;
            pc_d       = bus.branch_taken ? bus.branch_target : jump_target;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.imem_ready) begin
                        if (bus.stall) begin
                            buf_d   = bus.imem_rdata;
                            state_d = HELD;
                        end else begin
                            ifid_load = ~bus.flush;
                            pc_d      = pc_plus4;
                        end
                    end
                end
                HELD: begin
                    if (!bus.stall) begin
                        ifid_load    = ~bus.flush;
                        ifid_instr_d = buf_q;
                        pc_d         = pc_plus4;
                        state_d      = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ifid_load),
        .hold_i  (bus.stall),
        .clear_i (ifid_clear),
        .instr_i (ifid_instr_d),
        .pc4_i   (pc_plus4),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc4_o   (if_id_pc4)
    );

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.if_id_valid = if_id_valid;
    assign bus.if_id_instr = if_id_instr;
    assign bus.if_id_pc4   = if_id_pc4;
    assign bus.opcode      = if_id_instr[XLEN-1 -: OPCODE_W];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_q + {31'd0, ifid_load};
            bubbles_q <= bubbles_q + {31'd0, ~if_id_valid};
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Directed and random checks of fetch_stage against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (RPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: architectural view of the stage.
    logic [31:0] m_pc, m_buf, m_instr, m_pc4, m_fetched, m_bubbles;
    logic        m_held, m_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, rdy, input logic [31:0] rd,
                         input logic st, fl, br, input logic [31:0] tg, input logic jp);
        logic [31:0] w;
        if (!r) begin
            m_pc = RPC; m_held = 1'b0; m_buf = '0; m_v = 1'b0;
            m_instr = '0; m_pc4 = '0; m_fetched = '0; m_bubbles = '0;
            return;
        end
        if (!m_v) m_bubbles = m_bubbles + 1;
        if (br || jp) begin
            m_pc   = br ? tg : {m_pc4[31:28], m_instr[25:0], 2'b00};
            m_v    = 1'b0;
            m_held = 1'b0;
            return;
        end
        if (fl) m_v = 1'b0;
        if (!m_held && rdy && st) begin
            m_buf  = rd;
            m_held = 1'b1;
        end else if (!st && (m_held || rdy)) begin
            w      = m_held ? m_buf : rd;
            m_held = 1'b0;
            if (!fl) begin
                m_v = 1'b1; m_instr = w; m_pc4 = m_pc + 4;
                m_fetched = m_fetched + 1;
            end
            m_pc = m_pc + 4;
        end
    endtask

    task automatic check_all();
        chk("imem_req",    {31'd0, bus.imem_req},    {31'd0, ~m_held});
        chk("imem_addr",   bus.imem_addr,            m_pc);
        chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_v});
        chk("if_id_instr", bus.if_id_instr,          m_instr);
        chk("if_id_pc4",   bus.if_id_pc4,            m_pc4);
        chk("opcode",      {26'd0, bus.opcode},      {26'd0, m_instr[31:26]});
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    endtask

    task automatic step(input logic r, rdy, input logic [31:0] rd,
                        input logic st, fl, br, input logic [31:0] tg, input logic jp);
        rst_n = r; bus.imem_ready = rdy; bus.imem_rdata = rd; bus.stall = st;
        bus.flush = fl; bus.branch_taken = br; bus.branch_target = tg; bus.jump = jp;
        model(r, rdy, rd, st, fl, br, tg, jp);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] f0;
        rst_n = 1'b0; bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.stall = 1'b0;
        bus.flush = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0; bus.jump = 1'b0;
        m_pc = '0; m_buf = '0; m_instr = '0; m_pc4 = '0; m_fetched = '0; m_bubbles = '0;
        m_held = 1'b0; m_v = 1'b0;

        // Reset state
        step(0, 1, 32'hDEAD_BEEF, 1, 1, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        chk("rst_addr",  bus.imem_addr, 32'h100);
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);

        // Sequential fetch from RESET_PC
        step(1, 1, 32'h2001_0001, 0, 0, 0, 0, 0);
        chk("seq_pc4_first", bus.if_id_pc4, 32'h104);
        chk("seq_addr_104",  bus.imem_addr, 32'h104);
        step(1, 1, 32'h2001_0002, 0, 0, 0, 0, 0);
        chk("seq_addr_108",  bus.imem_addr, 32'h108);

        // Stall while the 0x108 word arrives
        step(1, 1, 32'h8C22_0108, 1, 0, 0, 0, 0);
        chk("stall_req_off",  {31'd0, bus.imem_req}, 32'd0);
        chk("stall_hold_pc4", bus.if_id_pc4, 32'h108);
        step(1, 1, 32'h1111_1111, 1, 0, 0, 0, 0);
        step(1, 1, 32'h2222_2222, 1, 0, 0, 0, 0);
        chk("stall_hold_ins", bus.if_id_instr, 32'h2001_0002);
        step(1, 1, 32'h3333_3333, 0, 0, 0, 0, 0);
        chk("unstall_instr", bus.if_id_instr, 32'h8C22_0108);
        chk("unstall_addr",  bus.imem_addr, 32'h10C);

        // Jump redirect from IF/ID
        step(1, 0, 32'h0, 0, 0, 1, 32'h1000_000C, 0);
        step(1, 1, 32'h0800_0040, 0, 0, 0, 0, 0);
        chk("j_setup_pc4", bus.if_id_pc4, 32'h1000_0010);
        step(1, 1, 32'h4444_4444, 1, 0, 0, 0, 1);
        chk("jump_addr",  bus.imem_addr, 32'h1000_0100);
        chk("jump_valid", {31'd0, bus.if_id_valid}, 32'd0);

        // Branch beats jump
        step(1, 1, 32'h5555_5555, 0, 0, 1, 32'h200, 1);
        chk("br_prio", bus.imem_addr, 32'h200);

        // Reset while HELD with a response arriving
        step(1, 1, 32'h6666_6666, 1, 0, 0, 0, 0);
        step(0, 1, 32'h7777_7777, 1, 1, 1, 32'h300, 1);
        chk("rst_held_addr", bus.imem_addr, RPC);
        chk("rst_held_req",  {31'd0, bus.imem_req}, 32'd1);

        // PC wraps at the top of the address space
        step(1, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        f0 = m_fetched;
        step(1, 1, 32'h0000_0020, 0, 0, 0, 0, 0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc4",  bus.if_id_pc4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("wrap_perf", perf_fetched, f0 + 1);
`endif

        // Flush drops a same-cycle accept but the PC advances
        step(1, 1, 32'h8888_8888, 0, 1, 0, 0, 0);
        chk("flush_addr", bus.imem_addr, 32'h4);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 9) < 7),
                 $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 15) == 0),
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
